inst_d: RTL and testbench

//  Instruction decode stage, directly downstream of instruction fetch.
//  - Latches the fetched instruction and PC+4 in the IF/ID register.
//  - Reads operands from a 32x32 register file with a writeback port, and decodes opcode [31:26].
//  - Detects load-use hazards and drives the fetch-stage stall.
//  - Emits a registered ID/EX bundle to execute.
//  - ISA fields: op[31:26] rs[25:21] rt[20:16] rd[15:11] imm[15:0].

---
 rtl/inst_d_if.sv | 41 ++++
 rtl/inst_d.sv | 198 +++++++++++++++++++
 tb/tb_inst_d.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_d_if.sv
// Decode-stage bus: groups the fetch-side inputs, the writeback port, the hazard
// and control inputs from EX, and the registered ID/EX bundle.
//   master: driver side (fetch/EX/WB models); drives inputs, observes outputs.
//   slave : the decode stage itself.
interface inst_d_if;
  // Fetch side
  logic [31:0] instr_in;
  logic [31:0] pc4_in;
  logic        hazard;
  // EX feedback
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_dest;
  // Writeback port
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  // ID/EX bundle
  logic [5:0]  ex_op;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [31:0] ex_pc4;
  logic        halted;

  modport master (
    output instr_in, pc4_in, flush, ex_mem_read, ex_dest, wb_en, wb_rd, wb_data,
    input  hazard, ex_op, ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_reg_write,
           ex_mem_rd, ex_mem_wr, ex_pc4, halted
  );

  modport slave (
    input  instr_in, pc4_in, flush, ex_mem_read, ex_dest, wb_en, wb_rd, wb_data,
    output hazard, ex_op, ex_rs_val, ex_rt_val, ex_imm, ex_rd, ex_reg_write,
           ex_mem_rd, ex_mem_wr, ex_pc4, halted
  );
endinterface

// File: rtl/inst_d.sv
// Instruction decode stage.
// Holds the IF/ID register, a 32x32 register file with a bypassed writeback port,
// opcode decode, load-use hazard detection and the registered ID/EX bundle.
// Ports:
//   clk    - clock, all state updates on posedge
//   rst    - synchronous active-high reset
//   bus_io - inst_d_if.slave: fetch inputs, EX feedback, writeback, hazard, ID/EX bundle
module inst_d #(
  parameter int unsigned NREGS     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  inst_d_if.slave  bus_io
);

  localparam logic [5:0] OpAluLast = 6'b001011;
  localparam logic [5:0] OpLdw     = 6'b001100;
  localparam logic [5:0] OpStw     = 6'b001101;
  localparam logic [5:0] OpBz      = 6'b001110;
  localparam logic [5:0] OpBeq     = 6'b001111;
  localparam logic [5:0] OpJr      = 6'b010000;
  localparam logic [5:0] OpHalt    = 6'b010001;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] pc4;
  } idex_t;

  // State
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  idex_t       idex_q, idex_d;
  logic        halted_q, halted_d;
  logic [31:0] rf_q [NREGS];

  // Instruction fields from IF/ID
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd_f;
  logic [15:0] imm;
  assign op   = ifid_instr_q[31:26];
  assign rs   = ifid_instr_q[25:21];
  assign rt   = ifid_instr_q[20:16];
  assign rd_f = ifid_instr_q[15:11];
  assign imm  = ifid_instr_q[15:0];

  // Register read with same-cycle writeback bypass; r0 always reads zero.
  logic [31:0] rs_rd, rt_rd;
  always_comb begin
    rs_rd = '0;
    rt_rd = '0;
    if (rs != 5'd0) begin
      rs_rd = (bus_io.wb_en && bus_io.wb_rd == rs) ? bus_io.wb_data : rf_q[rs];
    end
    if (rt != 5'd0) begin
      rt_rd = (bus_io.wb_en && bus_io.wb_rd == rt) ? bus_io.wb_data : rf_q[rt];
    end
  end

  // Opcode decode
  logic       defined, rs_used, rt_used, mem_rd, mem_wr, is_halt;
  logic [4:0] dest;
  always_comb begin
    defined = 1'b0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    is_halt = 1'b0;
    dest    = '0;
    if (op <= OpAluLast) begin
      // Even ALU opcodes are R-type, odd ones take the immediate.
      defined = 1'b1;
      rs_used = 1'b1;
      if (!op[0]) begin
        rt_used = 1'b1;
        dest    = rd_f;
      end else begin
        dest    = rt;
      end
    end else begin
      case (op)
        OpLdw: begin
          defined = 1'b1;
          rs_used = 1'b1;
          mem_rd  = 1'b1;
          dest    = rt;
        end
        OpStw, OpBeq: begin
          defined = 1'b1;
          rs_used = 1'b1;
          rt_used = 1'b1;
          mem_wr  = (op == OpStw);
        end
        OpBz, OpJr: begin
          defined = 1'b1;
          rs_used = 1'b1;
        end
        OpHalt: begin
          defined = 1'b1;
          is_halt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Decoded bundle; undefined opcodes collapse to a bubble.
  idex_t dec;
  always_comb begin
    dec = '0;
    if (defined) begin
      dec.op        = op;
      dec.rs_val    = rs_used ? rs_rd : '0;
      dec.rt_val    = rt_used ? rt_rd : '0;
      dec.imm       = {{16{imm[15]}}, imm};
      dec.rd        = dest;
      dec.reg_write = (dest != 5'd0);
      dec.mem_rd    = mem_rd;
      dec.mem_wr    = mem_wr;
      dec.pc4       = ifid_pc4_q;
    end
  end

  // Load-use hazard on the IF/ID instruction; a flush or halt makes it moot.
  logic hazard;
  always_comb begin
    hazard = bus_io.ex_mem_read && (bus_io.ex_dest != 5'd0) &&
             ((rs_used && bus_io.ex_dest == rs) || (rt_used && bus_io.ex_dest == rt)) &&
             !bus_io.flush && !halted_q;
  end

  // Next-state: flush > halted > hazard > advance
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    idex_d       = '0;
    halted_d     = halted_q;
    if (bus_io.flush) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = '0;
    end else if (halted_q || hazard) begin
      // IF/ID holds, bubble goes to EX
    end else begin
      ifid_instr_d = bus_io.instr_in;
      ifid_pc4_d   = bus_io.pc4_in;
      idex_d       = dec;
      if (is_halt) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      idex_q       <= '0;
      halted_q     <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      idex_q       <= idex_d;
      halted_q     <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
    end else if (bus_io.wb_en && bus_io.wb_rd != 5'd0) begin
      rf_q[bus_io.wb_rd] <= bus_io.wb_data;
    end
  end

  // Outputs
  assign bus_io.hazard       = hazard;
  assign bus_io.ex_op        = idex_q.op;
  assign bus_io.ex_rs_val    = idex_q.rs_val;
  assign bus_io.ex_rt_val    = idex_q.rt_val;
  assign bus_io.ex_imm       = idex_q.imm;
  assign bus_io.ex_rd        = idex_q.rd;
  assign bus_io.ex_reg_write = idex_q.reg_write;
  assign bus_io.ex_mem_rd    = idex_q.mem_rd;
  assign bus_io.ex_mem_wr    = idex_q.mem_wr;
  assign bus_io.ex_pc4       = idex_q.pc4;
  assign bus_io.halted       = halted_q;

endmodule

// File: tb/tb_inst_d.sv
// Scoreboard bench for inst_d: stimulus pushes expected values tagged with the
// cycle they must appear on; a negedge monitor pops and compares them.
module tb_inst_d;

  localparam int KBund = 0;
  localparam int KHaz  = 1;
  localparam int KHalt = 2;
  localparam logic [31:0] Nop  = 32'h0000_0000;
  localparam logic [31:0] Dead = 32'h0000_DEAD;

  typedef struct {
    int           cyc;
    int           kind;
    logic [141:0] val;
    string        nm;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  inst_d_if bus ();

  inst_d dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [141:0] bnd(logic [5:0] op, logic [31:0] rsv, logic [31:0] rtv,
                                       logic [31:0] imm, logic [4:0] rd, logic rw,
                                       logic mr, logic mw, logic [31:0] pc4);
    return {op, rsv, rtv, imm, rd, rw, mr, mw, pc4};
  endfunction

  function automatic logic [141:0] actual(int kind);
    if (kind == KHaz)  return {141'b0, bus.hazard};
    if (kind == KHalt) return {141'b0, bus.halted};
    return {bus.ex_op, bus.ex_rs_val, bus.ex_rt_val, bus.ex_imm, bus.ex_rd,
            bus.ex_reg_write, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_pc4};
  endfunction

  task automatic exp_bund(int at, logic [141:0] v, string nm);
    exp_t e;
    e.cyc = at; e.kind = KBund; e.val = v; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic exp_bit(int at, int kind, logic b, string nm);
    exp_t e;
    e.cyc = at; e.kind = kind; e.val = {141'b0, b}; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [141:0] a;
        a = actual(sb[i].kind);
        checks++;
        if (a !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].nm, cyc, a, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed cyc=%0d got=none want=%h", sb[i].nm, sb[i].cyc, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [31:0] instr, logic [31:0] pc4);
    bus.instr_in = instr;
    bus.pc4_in   = pc4;
  endtask

  task automatic wb(logic en, logic [4:0] rd, logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drv(Nop, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    bus.flush       = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_dest     = 5'd0;
    exp_bund(1, '0, "reset_bundle");
    exp_bit(1, KHalt, 1'b0, "reset_halted");
    exp_bit(1, KHaz, 1'b0, "reset_hazard");
    step(); step();

    // ADDI r1,r0,0x8000: sign extension, two-edge latency
    rst = 1'b0;
    drv(enc_i(6'd1, 5'd0, 5'd1, 16'h8000), 32'h104);
    exp_bund(cyc + 2, bnd(6'd1, 32'h0, 32'h0, 32'hFFFF_8000, 5'd1, 1'b1, 1'b0, 1'b0, 32'h104),
             "addi_sext");
    step();
    drv(Nop, 32'h0);
    step();

    // ADD r2,r5,r5 with writeback to r5 in the same cycle it is decoded
    drv(enc_r(6'd0, 5'd5, 5'd5, 5'd2), 32'h200);
    exp_bund(cyc + 2, bnd(6'd0, Dead, Dead, 32'h1000, 5'd2, 1'b1, 1'b0, 1'b0, 32'h200),
             "wb_bypass");
    step();
    wb(1'b1, 5'd5, Dead);
    drv(Nop, 32'h0);
    step();

    // r5 now held in the file
    wb(1'b0, 5'd0, 32'h0);
    drv(enc_r(6'd0, 5'd5, 5'd0, 5'd3), 32'h300);
    exp_bund(cyc + 2, bnd(6'd0, Dead, 32'h0, 32'h1800, 5'd3, 1'b1, 1'b0, 1'b0, 32'h300),
             "rf_store");
    step();
    drv(Nop, 32'h0);
    step();

    // Load-use hazard on ADD r4,r3,r1 (r1 = 0x11)
    drv(enc_r(6'd0, 5'd3, 5'd1, 5'd4), 32'h400);
    wb(1'b1, 5'd1, 32'h11);
    step();
    wb(1'b0, 5'd0, 32'h0);
    bus.ex_mem_read = 1'b1;
    bus.ex_dest     = 5'd3;
    drv(Nop, 32'h0);
    exp_bit(cyc, KHaz, 1'b1, "hazard_hi");
    exp_bund(cyc + 1, '0, "stall_bubble");
    step();
    bus.ex_mem_read = 1'b0;
    bus.ex_dest     = 5'd0;
    exp_bit(cyc, KHaz, 1'b0, "hazard_lo");
    exp_bund(cyc + 1, bnd(6'd0, 32'h0, 32'h11, 32'h2000, 5'd4, 1'b1, 1'b0, 1'b0, 32'h400),
             "after_stall");
    step();

    // Same hazard with flush: flush wins, IF/ID squashed
    drv(enc_r(6'd0, 5'd3, 5'd1, 5'd4), 32'h500);
    step();
    bus.ex_mem_read = 1'b1;
    bus.ex_dest     = 5'd3;
    bus.flush       = 1'b1;
    drv(enc_i(6'd1, 5'd0, 5'd6, 16'h0007), 32'h600);
    exp_bit(cyc, KHaz, 1'b0, "flush_hazard");
    exp_bund(cyc + 1, '0, "flush_bubble");
    step();
    bus.ex_mem_read = 1'b0;
    bus.ex_dest     = 5'd0;
    bus.flush       = 1'b0;
    drv(Nop, 32'h0);
    exp_bund(cyc + 1, '0, "flush_ifid_nop");
    step();

    // Decode table: LDW, STW, dest r0, undefined, HALT
    drv(enc_i(6'd12, 5'd1, 5'd7, 16'h0004), 32'h800);
    exp_bund(cyc + 2, bnd(6'd12, 32'h11, 32'h0, 32'h4, 5'd7, 1'b1, 1'b1, 1'b0, 32'h800), "ldw");
    step();
    drv(enc_i(6'd13, 5'd5, 5'd1, 16'hFFFC), 32'h804);
    exp_bund(cyc + 2, bnd(6'd13, Dead, 32'h11, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0, 1'b1, 32'h804),
             "stw");
    step();
    drv(enc_i(6'd1, 5'd1, 5'd0, 16'h0001), 32'h808);
    exp_bund(cyc + 2, bnd(6'd1, 32'h11, 32'h0, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h808),
             "dest_r0");
    step();
    drv(enc_i(6'd63, 5'd5, 5'd5, 16'h1234), 32'h80C);
    exp_bund(cyc + 2, '0, "undef_op");
    step();
    drv(enc_i(6'd17, 5'd5, 5'd5, 16'h0010), 32'h810);
    exp_bund(cyc + 2, bnd(6'd17, 32'h0, 32'h0, 32'h10, 5'd0, 1'b0, 1'b0, 1'b0, 32'h810),
             "halt_decode");
    exp_bit(cyc + 1, KHalt, 1'b0, "halted_pre");
    exp_bit(cyc + 2, KHalt, 1'b1, "halted_set");
    step();
    drv(enc_i(6'd1, 5'd5, 5'd1, 16'h0001), 32'h814);
    step();
    drv(enc_r(6'd0, 5'd1, 5'd1, 5'd2), 32'h818);
    bus.ex_mem_read = 1'b1;
    bus.ex_dest     = 5'd5;
    exp_bit(cyc, KHaz, 1'b0, "halt_hazard");
    exp_bund(cyc + 1, '0, "halt_bubble1");
    step();
    bus.ex_mem_read = 1'b0;
    bus.ex_dest     = 5'd0;
    exp_bund(cyc + 1, '0, "halt_bubble2");
    exp_bit(cyc + 1, KHalt, 1'b1, "halted_sticky");
    step();

    // Reset clears halt
    rst = 1'b1;
    exp_bund(cyc + 1, '0, "rst_bundle");
    exp_bit(cyc + 1, KHalt, 1'b0, "rst_halted");
    step();

    // Writes to r0 are dropped and never bypassed
    rst = 1'b0;
    wb(1'b1, 5'd0, 32'h5);
    drv(enc_r(6'd0, 5'd0, 5'd0, 5'd1), 32'h900);
    step();
    drv(Nop, 32'h0);
    exp_bund(cyc + 1, bnd(6'd0, 32'h0, 32'h0, 32'h800, 5'd1, 1'b1, 1'b0, 1'b0, 32'h900),
             "r0_zero");
    step();

    // Reset mid-stream discards IF/ID and register contents
    wb(1'b1, 5'd9, 32'h99);
    drv(enc_r(6'd0, 5'd9, 5'd9, 5'd3), 32'hA00);
    step();
    wb(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    drv(Nop, 32'h0);
    exp_bund(cyc + 1, '0, "rst_mid");
    step();
    rst = 1'b0;
    drv(enc_r(6'd0, 5'd9, 5'd9, 5'd3), 32'hA04);
    exp_bund(cyc + 2, bnd(6'd0, 32'h0, 32'h0, 32'h1800, 5'd3, 1'b1, 1'b0, 1'b0, 32'hA04),
             "rst_clears_rf");
    step();
    drv(Nop, 32'h0);
    repeat (4) step();

    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s never_checked got=none want=%h", sb[0].nm, sb[0].val);
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
